dequant_stream: RTL

DEQUANT_STREAM -- requirements
Module: dequant_stream

---
 rtl/dequant_stream.sv | 88 ++++++++
 1 files changed

// File: rtl/dequant_stream.sv
// Streaming int8 dequantiser: out = sat32(rnd((x - offset) * qmul, shift)), 3-stage pipeline.
// Define DEQUANT_ROUND_EN for round-half-up before the shift; otherwise the shift floors.
module dequant_stream (
    input  logic        clk,
    input  logic        clr,
    input  logic        cfg_en,
    input  logic [31:0] cfg_qmul,
    input  logic [3:0]  cfg_shift,
    input  logic [31:0] cfg_offset,
    output logic        cfg_ready,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_count
);

    logic [31:0]        r_qmul;
    logic [3:0]         r_shift;
    logic [31:0]        r_offset;
    logic               r_v1, r_v2, r_v3;
    logic signed [32:0] r_diff;
    logic signed [64:0] r_prod;
    logic [31:0]        r_out;
    logic [15:0]        r_cnt;

    logic               w_adv;
    logic               w_cfg_acc;
    logic signed [65:0] w_rnd_add;
    logic signed [65:0] w_sum;
    logic signed [65:0] w_shr;
    logic [31:0]        w_sat;

    // Whole pipeline moves in lockstep; only a held output stalls it.
    assign w_adv     = !(r_v3 && !out_ready);
    assign cfg_ready = !(r_v1 || r_v2 || r_v3);
    assign w_cfg_acc = cfg_en && cfg_ready;
    assign in_ready  = w_adv && !cfg_en;
    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign out_count = r_cnt;

    always_comb begin
        w_rnd_add = '0;
`ifdef DEQUANT_ROUND_EN
        if (r_shift != 4'd0) w_rnd_add = 66'sd1 <<< (r_shift - 4'd1);
`endif
        w_sum = $signed({r_prod[64], r_prod}) + w_rnd_add;
        w_shr = w_sum >>> r_shift;
        // Anything not representable as int32 clamps to the nearest rail.
        if (w_shr[65:31] == {35{w_shr[65]}}) w_sat = w_shr[31:0];
        else                                 w_sat = w_shr[65] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_qmul   <= '0;
            r_shift  <= '0;
            r_offset <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_diff   <= '0;
            r_prod   <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_cfg_acc) begin
                r_qmul   <= cfg_qmul;
                r_shift  <= cfg_shift;
                r_offset <= cfg_offset;
            end
            if (w_adv) begin
                r_v1   <= in_valid && in_ready;
                r_diff <= $signed({{25{in_data[7]}}, in_data}) - $signed({r_offset[31], r_offset});
                r_v2   <= r_v1;
                r_prod <= $signed({{32{r_diff[32]}}, r_diff}) * $signed({{33{r_qmul[31]}}, r_qmul});
                r_v3   <= r_v2;
                if (r_v2) r_out <= w_sat;
            end
            if (w_cfg_acc)                r_cnt <= '0;
            else if (r_v3 && out_ready)   r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
